// File: rtl/cart_rom_arbiter_if.sv
// Bus bundle between the cartridge ROM arbiter (slave side) and its requesters
// plus the shared memory (master side).
interface cart_rom_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  // Handshakes: dl_wr is a one-cycle strobe accepted when dl_wait is low.
  // gbN_req is a level held with a stable gbN_addr until the one-cycle
  // gbN_ack; gbN_data is valid with ack and held until the next ack.
  logic              dl_active;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [DATA_W-1:0] dl_data;
  logic              dl_wait;
  logic              dl_overrun;
  logic              gb1_req;
  logic [ADDR_W-1:0] gb1_addr;
  logic              gb1_ack;
  logic [DATA_W-1:0] gb1_data;
  logic              gb2_req;
  logic [ADDR_W-1:0] gb2_addr;
  logic              gb2_ack;
  logic [DATA_W-1:0] gb2_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [1:0]        arb_state;

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    output gb1_req, gb1_addr, gb2_req, gb2_addr, mem_dout,
    input  dl_wait, dl_overrun, gb1_ack, gb1_data, gb2_ack, gb2_data,
    input  mem_addr, mem_we, mem_din, arb_state
  );

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    input  gb1_req, gb1_addr, gb2_req, gb2_addr, mem_dout,
    output dl_wait, dl_overrun, gb1_ack, gb1_data, gb2_ack, gb2_data,
    output mem_addr, mem_we, mem_din, arb_state
  );
endinterface

// File: rtl/cart_rom_arbiter.sv
// Shares one single-port cartridge ROM between the download writer and two
// Gameboy cart readers. Optional last-address hit cache: ARB_HIT_CACHE_EN.
module cart_rom_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input logic              clk_sys,
  input logic              reset_n,
  cart_rom_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t            state;
  logic              pending;
  logic              overrun;
  logic              rr;    // side to favour on a tie: 0 = gb1, 1 = gb2
  logic              gnt;   // side owning the current read
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              ack1, ack2;
  logic [DATA_W-1:0] data1, data2;

  logic              any_req;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic              hit;
  logic              hit_busy;

  assign any_req  = bus.gb1_req | bus.gb2_req;
  assign sel      = (bus.gb1_req & bus.gb2_req) ? rr : bus.gb2_req;
  assign sel_addr = sel ? bus.gb2_addr : bus.gb1_addr;

`ifdef ARB_HIT_CACHE_EN
  logic [ADDR_W-1:0] last1, last2;
  logic              valid1, valid2;
  logic              hit_q, hit_side;

  assign hit      = sel ? (valid2 && (bus.gb2_addr == last2))
                        : (valid1 && (bus.gb1_addr == last1));
  assign hit_busy = hit_q;
`else
  assign hit      = 1'b0;
  assign hit_busy = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      rr         <= 1'b0;
      gnt        <= 1'b0;
      cnt        <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
      ack1       <= 1'b0;
      ack2       <= 1'b0;
      data1      <= '0;
      data2      <= '0;
`ifdef ARB_HIT_CACHE_EN
      last1      <= '0;
      last2      <= '0;
      valid1     <= 1'b0;
      valid2     <= 1'b0;
      hit_q      <= 1'b0;
      hit_side   <= 1'b0;
`endif
    end else begin
      ack1 <= 1'b0;
      ack2 <= 1'b0;

      if (bus.dl_wr) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
          wr_addr <= bus.dl_addr;
          wr_data <= bus.dl_data;
        end
      end

`ifdef ARB_HIT_CACHE_EN
      // A hit found last cycle is acknowledged now from the held data.
      if (hit_q) begin
        hit_q <= 1'b0;
        if (hit_side) ack2 <= 1'b1;
        else          ack1 <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (pending) begin
            state      <= WRITE;
            mem_we_q   <= 1'b1;
            mem_addr_q <= wr_addr;
            mem_din_q  <= wr_data;
`ifdef ARB_HIT_CACHE_EN
            valid1     <= 1'b0;
            valid2     <= 1'b0;
`endif
          end else if (!bus.dl_active && any_req && !hit_busy) begin
            if (hit) begin
`ifdef ARB_HIT_CACHE_EN
              hit_q    <= 1'b1;
              hit_side <= sel;
              rr       <= ~sel;
`endif
            end else begin
              state      <= READ;
              gnt        <= sel;
              mem_addr_q <= sel_addr;
              cnt        <= LAT;
            end
          end
        end

        WRITE: begin
          pending   <= 1'b0;
          mem_we_q  <= 1'b0;
          mem_din_q <= '0;
          state     <= IDLE;
        end

        READ: begin
          if (cnt == 3'd0) begin
            if (gnt) begin
              data2 <= bus.mem_dout;
              ack2  <= 1'b1;
            end else begin
              data1 <= bus.mem_dout;
              ack1  <= 1'b1;
            end
            rr    <= ~gnt;
            state <= IDLE;
`ifdef ARB_HIT_CACHE_EN
            if (gnt) begin
              last2  <= mem_addr_q;
              valid2 <= 1'b1;
            end else begin
              last1  <= mem_addr_q;
              valid1 <= 1'b1;
            end
`endif
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef ARB_HIT_CACHE_EN
      // Download in progress: cached words may be stale.
      if (bus.dl_active) begin
        valid1 <= 1'b0;
        valid2 <= 1'b0;
      end
`endif
    end
  end

  assign bus.dl_wait    = pending;
  assign bus.dl_overrun = overrun;
  assign bus.gb1_ack    = ack1;
  assign bus.gb1_data   = data1;
  assign bus.gb2_ack    = ack2;
  assign bus.gb2_data   = data2;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.arb_state  = state;
endmodule

// File: tb/tb_cart_rom_arbiter.sv
// Directed bench for cart_rom_arbiter: vector table plus hand-written
// sequences for contention, write-during-read, gating and reset.
module tb_cart_rom_arbiter;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 2;
  localparam int MISS_LAT = MEM_LAT + 1;

`ifdef ARB_HIT_CACHE_EN
  localparam int              HIT_LAT      = 1;
  localparam logic [23:0]     REP_MEM_ADDR = 24'h20;
  localparam int              CONT_GAP     = 2;
  localparam logic [23:0]     CONT_ADDR2   = 24'h10;
`else
  localparam int              HIT_LAT      = MISS_LAT;
  localparam logic [23:0]     REP_MEM_ADDR = 24'h10;
  localparam int              CONT_GAP     = 4;
  localparam logic [23:0]     CONT_ADDR2   = 24'h20;
`endif

  typedef struct {
    logic [1:0]  kind;   // 0 = download write, 1 = gb1 read, 2 = gb2 read
    logic [23:0] addr;
    logic [15:0] data;   // write data or expected read data
    int          exp_cyc; // dl_wait cycles or ack latency
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cart_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  cart_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory model: synchronous write, MEM_LAT-stage read pipeline.
  logic [15:0] mem_arr [0:4095];
  logic [15:0] rd_pipe [0:MEM_LAT-1];

  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_addr[11:0]] <= bus.mem_din;
    rd_pipe[0] <= mem_arr[bus.mem_addr[11:0]];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_dout = rd_pipe[MEM_LAT-1];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n && bus.arb_state == 2'd2) check("we_in_read", 32'(bus.mem_we), 32'd0);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),   32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we),     32'd0);
    check({tag, "_mem_din"},   32'(bus.mem_din),    32'd0);
    check({tag, "_dl_wait"},   32'(bus.dl_wait),    32'd0);
    check({tag, "_overrun"},   32'(bus.dl_overrun), 32'd0);
    check({tag, "_acks"},      32'({bus.gb1_ack, bus.gb2_ack}), 32'd0);
    check({tag, "_gb1_data"},  32'(bus.gb1_data),   32'd0);
    check({tag, "_gb2_data"},  32'(bus.gb2_data),   32'd0);
    check({tag, "_state"},     32'(bus.arb_state),  32'd0);
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_write(input logic [23:0] a, input logic [15:0] d,
                          output int wait_n, output int we_n,
                          output logic [23:0] we_a, output logic [15:0] we_d);
    wait_n = 0; we_n = 0; we_a = '0; we_d = '0;
    bus.dl_wr = 1'b1; bus.dl_addr = a; bus.dl_data = d;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) bus.dl_wr = 1'b0;
      if (bus.dl_wait) wait_n++;
      if (bus.mem_we) begin
        we_n++; we_a = bus.mem_addr; we_d = bus.mem_din;
      end
    end
  endtask

  task automatic do_read(input int side, input logic [23:0] a,
                         output int lat, output logic [15:0] d, output int other_n,
                         output int again_n, output logic [23:0] ack_maddr);
    lat = -1; d = '0; other_n = 0; again_n = 0; ack_maddr = '0;
    if (side == 1) begin bus.gb1_req = 1'b1; bus.gb1_addr = a; end
    else           begin bus.gb2_req = 1'b1; bus.gb2_addr = a; end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if ((side == 1) ? bus.gb2_ack : bus.gb1_ack) other_n++;
      if ((side == 1) ? bus.gb1_ack : bus.gb2_ack) begin
        lat = k - 1;
        d = (side == 1) ? bus.gb1_data : bus.gb2_data;
        ack_maddr = bus.mem_addr;
        break;
      end
    end
    bus.gb1_req = 1'b0; bus.gb2_req = 1'b0;
    @(negedge clk);
    if ((side == 1) ? bus.gb1_ack : bus.gb2_ack) again_n++;
  endtask

  initial begin
    vec_t        vecs [8];
    int          wait_n, we_n, lat, other_n, again_n, ack_n, ack_cyc, we_cyc;
    logic [23:0] we_a, maddr;
    logic [15:0] we_d, rd;
    int          sides [$];
    int          cycs [$];
    logic [23:0] maddrs [$];
    logic [15:0] exp_q [$];

    vecs[0] = '{2'd0, 24'h000123, 16'hBEEF, 2};
    vecs[1] = '{2'd0, 24'h000010, 16'h1111, 2};
    vecs[2] = '{2'd0, 24'h000020, 16'h2222, 2};
    vecs[3] = '{2'd1, 24'h000123, 16'hBEEF, MISS_LAT};
    vecs[4] = '{2'd2, 24'h000010, 16'h1111, MISS_LAT};
    vecs[5] = '{2'd2, 24'h000010, 16'h1111, HIT_LAT};
    vecs[6] = '{2'd1, 24'h000020, 16'h2222, MISS_LAT};
    vecs[7] = '{2'd2, 24'h000020, 16'h2222, MISS_LAT};

    reset_n = 1'b0;
    bus.dl_active = 1'b0; bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
    bus.gb1_req = 1'b0; bus.gb1_addr = '0; bus.gb2_req = 1'b0; bus.gb2_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].kind == 2'd0) begin
        do_write(vecs[i].addr, vecs[i].data, wait_n, we_n, we_a, we_d);
        check($sformatf("v%0d_dl_wait_cyc", i), 32'(wait_n), 32'(vecs[i].exp_cyc));
        check($sformatf("v%0d_we_pulses", i), 32'(we_n), 32'd1);
        check($sformatf("v%0d_we_addr", i), 32'(we_a), 32'(vecs[i].addr));
        check($sformatf("v%0d_we_din", i), 32'(we_d), 32'(vecs[i].data));
        check($sformatf("v%0d_overrun", i), 32'(bus.dl_overrun), 32'd0);
      end else begin
        do_read(int'(vecs[i].kind), vecs[i].addr, lat, rd, other_n, again_n, maddr);
        check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_cyc));
        check($sformatf("v%0d_data", i), 32'(rd), 32'(vecs[i].data));
        check($sformatf("v%0d_other_ack", i), 32'(other_n), 32'd0);
        check($sformatf("v%0d_ack_pulse", i), 32'(again_n), 32'd0);
      end
      @(negedge clk);
    end

    // Contention: both sides held; grants alternate starting with gb1.
    bus.gb1_req = 1'b1; bus.gb1_addr = 24'h10;
    bus.gb2_req = 1'b1; bus.gb2_addr = 24'h20;
    for (int k = 1; k <= 40 && sides.size() < 4; k++) begin
      @(negedge clk);
      if (bus.gb1_ack) begin
        sides.push_back(1); cycs.push_back(k); maddrs.push_back(bus.mem_addr);
        exp_q.push_back(bus.gb1_data);
      end
      if (bus.gb2_ack) begin
        sides.push_back(2); cycs.push_back(k); maddrs.push_back(bus.mem_addr);
        exp_q.push_back(bus.gb2_data);
      end
    end
    bus.gb1_req = 1'b0; bus.gb2_req = 1'b0;
    check("cont_ack_count", 32'(sides.size()), 32'd4);
    for (int i = 0; i < sides.size() && i < 4; i++) begin
      check($sformatf("cont_side%0d", i), 32'(sides[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("cont_data%0d", i), 32'(exp_q[i]), (i % 2 == 0) ? 32'h1111 : 32'h2222);
      check($sformatf("cont_maddr%0d", i), 32'(maddrs[i]),
            (i % 2 == 0) ? 32'h10 : 32'(CONT_ADDR2));
      if (i > 0) check($sformatf("cont_gap%0d", i), 32'(cycs[i] - cycs[i-1]), 32'(CONT_GAP));
    end
    repeat (3) @(negedge clk);

    // Write (and an overrunning second write) arriving during a gb2 read.
    ack_cyc = -1; we_cyc = -1; we_n = 0; wait_n = 0; we_d = '0; we_a = '0;
    bus.gb2_req = 1'b1; bus.gb2_addr = 24'h123;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.dl_wait) wait_n++;
      if (bus.gb2_ack && ack_cyc < 0) begin ack_cyc = k; bus.gb2_req = 1'b0; end
      if (bus.mem_we) begin we_n++; we_cyc = k; we_a = bus.mem_addr; we_d = bus.mem_din; end
      if (k == 1) begin bus.dl_wr = 1'b1; bus.dl_addr = 24'h30; bus.dl_data = 16'h1234; end
      if (k == 2) begin bus.dl_addr = 24'h31; bus.dl_data = 16'h5555; end
      if (k == 3) bus.dl_wr = 1'b0;
    end
    bus.gb2_req = 1'b0;
    check("wdr_ack_seen", 32'(ack_cyc > 0), 32'd1);
    check("wdr_ack_before_we", 32'(ack_cyc > 0 && ack_cyc < we_cyc), 32'd1);
    check("wdr_gb2_data", 32'(bus.gb2_data), 32'hBEEF);
    check("wdr_we_pulses", 32'(we_n), 32'd1);
    check("wdr_we_addr", 32'(we_a), 32'h30);
    check("wdr_we_din", 32'(we_d), 32'h1234);
    check("wdr_wait_le5", 32'(wait_n >= 1 && wait_n <= MEM_LAT + 3), 32'd1);
    check("wdr_overrun", 32'(bus.dl_overrun), 32'd1);
    do_read(1, 24'h30, lat, rd, other_n, again_n, maddr);
    check("wdr_readback", 32'(rd), 32'h1234);
    do_read(1, 24'h31, lat, rd, other_n, again_n, maddr);
    check("wdr_overrun_no_write", 32'(rd), 32'h0);

    // dl_active gating.
    ack_n = 0;
    bus.dl_active = 1'b1; bus.gb1_req = 1'b1; bus.gb1_addr = 24'h10;
    repeat (20) begin
      @(negedge clk);
      if (bus.gb1_ack) ack_n++;
    end
    check("gate_no_ack", 32'(ack_n), 32'd0);
    bus.dl_active = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.gb1_ack) begin lat = k - 1; rd = bus.gb1_data; break; end
    end
    bus.gb1_req = 1'b0;
    check("gate_release_lat", 32'(lat), 32'(MISS_LAT));
    check("gate_data", 32'(rd), 32'h1111);
    repeat (2) @(negedge clk);

    // Reset in the middle of a read.
    bus.gb1_req = 1'b1; bus.gb1_addr = 24'h20;
    @(negedge clk);
    check("mid_in_read", 32'(bus.arb_state), 32'd2);
    reset_n = 1'b0;
    bus.gb1_req = 1'b0;
    ack_n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.gb1_ack || bus.gb2_ack) ack_n++;
    end
    check("mid_no_ack", 32'(ack_n), 32'd0);
    check_reset_outputs("mid");
    reset_n = 1'b1;
    @(negedge clk);

    // After reset rr favours gb1.
    bus.gb1_req = 1'b1; bus.gb1_addr = 24'h10;
    bus.gb2_req = 1'b1; bus.gb2_addr = 24'h20;
    sides.delete(); lat = -1; ack_cyc = -1;
    for (int k = 1; k <= 30 && sides.size() < 2; k++) begin
      @(negedge clk);
      if (bus.gb1_ack) begin
        sides.push_back(1); lat = k - 1; rd = bus.gb1_data; bus.gb1_req = 1'b0;
      end
      if (bus.gb2_ack) begin
        sides.push_back(2); we_d = bus.gb2_data; bus.gb2_req = 1'b0;
      end
    end
    bus.gb1_req = 1'b0; bus.gb2_req = 1'b0;
    check("post_rst_acks", 32'(sides.size()), 32'd2);
    if (sides.size() == 2) begin
      check("post_rst_first", 32'(sides[0]), 32'd1);
      check("post_rst_second", 32'(sides[1]), 32'd2);
    end
    check("post_rst_lat", 32'(lat), 32'(MISS_LAT));
    check("post_rst_gb1_data", 32'(rd), 32'h1111);
    check("post_rst_gb2_data", 32'(we_d), 32'h2222);
    @(negedge clk);

    // Repeated read of the same address by gb1.
    do_read(1, 24'h10, lat, rd, other_n, again_n, maddr);
    check("rep_lat", 32'(lat), 32'(HIT_LAT));
    check("rep_data", 32'(rd), 32'h1111);
    check("rep_mem_addr", 32'(maddr), 32'(REP_MEM_ADDR));
    check("rep_ack_pulse", 32'(again_n), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
